sync_fifo_flex: RTL and testbench
=================================

// Module: sync_fifo_flex
// PURPOSE
//   Single-clock FIFO, successor to the dual-clock FIFO for same-domain buffering.
//   Any integer DEPTH is supported, not only powers of two.
//   Adds occupancy count, almost-full/almost-empty thresholds, synchronous flush,
//   a first-word-fall-through (FWFT) mode and sticky overflow/underflow error flags.
//   Sits between a producer and consumer in one clock domain: stream skid buffers, cmd queues.
// PARAMETERS
//   WIDTH      16  data width in bits (>=1)
//   DEPTH      8   number of entries (>=2, any integer)
//   FWFT       0   0: registered read, data 1 cycle after pop; 1: show-ahead, head word on o_rdata
//   AFULL_TH   6   o_afull asserted when count >= AFULL_TH (1..DEPTH)
//   AEMPTY_TH  2   o_aempty asserted when count <= AEMPTY_TH (0..DEPTH-1)
//   Derived: AW = clog2(DEPTH) pointer width, CW = clog2(DEPTH+1) count width
// PORTS
//   i_clk        in   1      clock
//   i_rst_n      in   1      async active-low reset
//   i_clr        in   1      synchronous flush, empties FIFO
//   i_push       in   1      write request
//   i_wdata      in   WIDTH  write data
//   i_pop        in   1      read request
//   o_rdata      out  WIDTH  read data
//   o_count      out  CW     stored word count, 0..DEPTH
//   o_full       out  1      count == DEPTH
//   o_empty      out  1      count == 0
//   o_afull      out  1      count >= AFULL_TH
//   o_aempty     out  1      count <= AEMPTY_TH
//   i_err_clr    in   1      clears sticky error flags
//   o_overflow   out  1      sticky: push rejected
//   o_underflow  out  1      sticky: pop rejected
// BEHAVIOUR
//   Reset values
//   - Reset is asynchronous, active low.
//   - wptr = rptr = 0, count = 0, o_rdata = 0.
//   - o_empty = 1, o_aempty = 1, o_full = 0, o_afull = 0, o_overflow = 0, o_underflow = 0.
//   - Memory array is not reset.
//   Pointers
//   - wptr and rptr run 0..DEPTH-1 and wrap to 0 after DEPTH-1 (explicit compare, no modulo-2^AW).
//   - Count is a separate CW-bit register, not derived from the pointers.
//   Accept rules, evaluated at the clock edge
//   - pop_ok  = i_pop & !o_empty
//   - push_ok = i_push & (!o_full | pop_ok)
//   - When full, push+pop in the same cycle are both accepted; count is unchanged.
//   - When empty, push+pop in the same cycle: the push is accepted, the pop is rejected and
//     o_underflow is set.
//   - count_next = count + push_ok - pop_ok.
//   Flags
//   - o_full, o_empty, o_afull and o_aempty are decoded from the registered count only.
//   - There is no combinational path from i_push or i_pop to any flag.
//   Read data, FWFT = 0
//   - On pop_ok, o_rdata <= mem[rptr]; the word is valid the cycle after the pop.
//   - Otherwise o_rdata holds its value, including across a rejected pop and across i_clr.
//   Read data, FWFT = 1
//   - o_rdata = mem[rptr] combinationally while !o_empty; o_rdata = 0 while o_empty.
//   - A word pushed into an empty FIFO appears on o_rdata the cycle after the push.
//   - pop_ok advances to the next word in the following cycle.
//   Error flags
//   - o_overflow is set on (i_push & !push_ok); o_underflow is set on (i_pop & !pop_ok).
//   - Both are cleared only by i_err_clr or reset.
//   - If set and clear occur in the same cycle, set wins.
//   Flush
//   - i_clr has priority over push and pop: wptr, rptr and count go to 0 next cycle.
//   - Push/pop presented in the i_clr cycle are ignored and raise no error flags.
//   - Sticky error flags are unaffected by i_clr.
//   Reset mid-operation
//   - All state returns immediately to reset values; stored data is lost.
// TESTING
//   1. Fill/drain, DEPTH=5 (non-power-of-2), FWFT=0: push 1..5 -> o_full=1, count=5.
//      Pop x5 -> o_rdata 1..5, each 1 cycle after its pop, then o_empty=1.
//   2. Wrap-around, DEPTH=5: repeat push 3 / pop 3 for 4 rounds -> data order preserved,
//      pointers wrap 4->0, count never exceeds 3.
//   3. Full boundary, DEPTH=5: with count=5, push+pop in one cycle -> both accepted, count stays 5,
//      o_overflow=0. Push alone -> rejected, o_overflow=1 until i_err_clr.
//   4. Empty boundary, FWFT=1: push 0xA5A5+pop on an empty FIFO -> count=1, o_underflow=1,
//      o_rdata=0xA5A5 next cycle. Pop -> o_rdata=0 and o_empty=1 the cycle after.
//   5. Thresholds, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2: push 0..8 words one per cycle -> o_aempty
//      deasserts at count=3, o_afull asserts at count=6, o_full asserts at count=8.
//   6. Flush/reset: at count=4, i_clr with push+pop -> next cycle count=0, o_empty=1, no error set.
//      Then at count=3, assert i_rst_n=0 mid-cycle -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sync_fifo_flex_if.sv
// sync_fifo_flex_if: producer/consumer bundle for sync_fifo_flex.
//   master: clr, push, wdata, pop, err_clr out; rdata, count, status flags in.
//   slave : the reverse, used by the FIFO itself.
interface sync_fifo_flex_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             clr;
    logic             push;
    logic [WIDTH-1:0] wdata;
    logic             pop;
    logic [WIDTH-1:0] rdata;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             afull;
    logic             aempty;
    logic             err_clr;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, push, wdata, pop, err_clr,
        input  rdata, count, full, empty, afull, aempty, overflow, underflow
    );

    modport slave (
        input  clr, push, wdata, pop, err_clr,
        output rdata, count, full, empty, afull, aempty, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO for any DEPTH >= 2, with occupancy count,
// almost-full/almost-empty thresholds, synchronous flush, optional show-ahead
// (FWFT) read and sticky overflow/underflow flags.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_flex_if.slave (clr, push/wdata, pop/rdata, count, flags,
//           err_clr, overflow, underflow)
module sync_fifo_flex #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 8,
    parameter bit          FWFT      = 1'b0,
    parameter int unsigned AFULL_TH  = 6,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_flex_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [CW-1:0] AfullC  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AemptyC = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          pop_ok, push_ok;
    logic          full, empty;

    assign full  = (count_q == DepthC);
    assign empty = (count_q == '0);

    // A pop frees a slot in the same edge, so a full FIFO still takes push+pop.
    assign pop_ok  = bus.pop & ~empty;
    assign push_ok = bus.push & (~full | pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (bus.clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (push_ok) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + AW'(1);
            if (pop_ok)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Set beats clear; requests in a flush cycle are ignored and flag nothing.
    always_comb begin
        overflow_d  = (overflow_q & ~bus.err_clr) | (~bus.clr & bus.push & ~push_ok);
        underflow_d = (underflow_q & ~bus.err_clr) | (~bus.clr & bus.pop & ~pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok && !bus.clr) mem[wptr_q] <= bus.wdata;
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.rdata = empty ? '0 : mem[rptr_q];
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q;
            // Holds across rejected pops and flushes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (pop_ok && !bus.clr) begin
                    rdata_q <= mem[rptr_q];
                end
            end
            assign bus.rdata = rdata_q;
        end
    endgenerate

    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.afull     = (count_q >= AfullC);
    assign bus.aempty    = (count_q <= AemptyC);
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: instance A (DEPTH=5, registered read) and
// instance B (DEPTH=8, FWFT). Read data is checked by scoreboard monitors.
module tb_sync_fifo_flex;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_flex_if #(.WIDTH(16), .DEPTH(5)) bus_a ();
    sync_fifo_flex_if #(.WIDTH(16), .DEPTH(8)) bus_b ();

    sync_fifo_flex #(
        .WIDTH(16), .DEPTH(5), .FWFT(1'b0), .AFULL_TH(4), .AEMPTY_TH(1)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    sync_fifo_flex #(
        .WIDTH(16), .DEPTH(8), .FWFT(1'b1), .AFULL_TH(6), .AEMPTY_TH(2)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    bit          a_take = 1'b0;
    bit          b_take = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: registered read, word is due the cycle after an accepted pop.
    initial begin
        bit take;
        forever begin
            @(posedge clk);
            take = a_take;
            @(negedge clk);
            if (take) begin
                if (qa.size() == 0) chk("a_rdata_noexp", 32'd1, 32'd0);
                else chk("a_rdata", 32'(bus_a.rdata), 32'(qa.pop_front()));
            end
        end
    end

    // Monitor B: show-ahead, head word must be on rdata whenever non-empty.
    initial begin
        forever begin
            @(posedge clk);
            if (b_take && qb.size() != 0) void'(qb.pop_front());
            @(negedge clk);
            if (rst_n) begin
                if (bus_b.empty) chk("b_rdata_empty", 32'(bus_b.rdata), 32'd0);
                else if (qb.size() == 0) chk("b_rdata_noexp", 32'd1, 32'd0);
                else chk("b_rdata_head", 32'(bus_b.rdata), 32'(qb[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic a_op(input bit push, input bit pop, input logic [15:0] wd,
                        input bit take, input logic [15:0] exp);
        bus_a.push  = push;
        bus_a.pop   = pop;
        bus_a.wdata = wd;
        if (take) qa.push_back(exp);
        a_take = take;
        step();
        bus_a.push = 1'b0;
        bus_a.pop  = 1'b0;
        a_take     = 1'b0;
    endtask

    task automatic b_op(input bit push, input bit pop, input logic [15:0] wd,
                        input bit qpush, input bit take);
        bus_b.push  = push;
        bus_b.pop   = pop;
        bus_b.wdata = wd;
        if (qpush) qb.push_back(wd);
        b_take = take;
        step();
        bus_b.push = 1'b0;
        bus_b.pop  = 1'b0;
        b_take     = 1'b0;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_a_count"}, 32'(bus_a.count), 32'd0);
        chk({tag, "_a_empty"}, 32'(bus_a.empty), 32'd1);
        chk({tag, "_a_aempty"}, 32'(bus_a.aempty), 32'd1);
        chk({tag, "_a_full"}, 32'(bus_a.full), 32'd0);
        chk({tag, "_a_afull"}, 32'(bus_a.afull), 32'd0);
        chk({tag, "_a_ovf"}, 32'(bus_a.overflow), 32'd0);
        chk({tag, "_a_unf"}, 32'(bus_a.underflow), 32'd0);
        chk({tag, "_a_rdata"}, 32'(bus_a.rdata), 32'd0);
    endtask

    task automatic chk_reset_b(input string tag);
        chk({tag, "_b_count"}, 32'(bus_b.count), 32'd0);
        chk({tag, "_b_empty"}, 32'(bus_b.empty), 32'd1);
        chk({tag, "_b_aempty"}, 32'(bus_b.aempty), 32'd1);
        chk({tag, "_b_full"}, 32'(bus_b.full), 32'd0);
        chk({tag, "_b_afull"}, 32'(bus_b.afull), 32'd0);
        chk({tag, "_b_ovf"}, 32'(bus_b.overflow), 32'd0);
        chk({tag, "_b_unf"}, 32'(bus_b.underflow), 32'd0);
        chk({tag, "_b_rdata"}, 32'(bus_b.rdata), 32'd0);
    endtask

    initial begin
        bus_a.clr = 0; bus_a.push = 0; bus_a.pop = 0; bus_a.wdata = '0; bus_a.err_clr = 0;
        bus_b.clr = 0; bus_b.push = 0; bus_b.pop = 0; bus_b.wdata = '0; bus_b.err_clr = 0;
        #12;
        chk_reset_a("rst");
        chk_reset_b("rst");
        rst_n = 1'b1;
        step();

        // Fill/drain on DEPTH=5.
        for (int i = 1; i <= 5; i++) a_op(1, 0, 16'(i), 0, '0);
        chk("fill_full", 32'(bus_a.full), 32'd1);
        chk("fill_count", 32'(bus_a.count), 32'd5);
        chk("fill_afull", 32'(bus_a.afull), 32'd1);
        for (int i = 1; i <= 5; i++) a_op(0, 1, '0, 1, 16'(i));
        chk("drain_empty", 32'(bus_a.empty), 32'd1);
        chk("drain_count", 32'(bus_a.count), 32'd0);

        // Wrap-around: pointers cross 4->0 several times.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) a_op(1, 0, 16'(16'h20 + 3 * r + k), 0, '0);
            chk("wrap_count", 32'(bus_a.count), 32'd3);
            for (int k = 0; k < 3; k++) a_op(0, 1, '0, 1, 16'(16'h20 + 3 * r + k));
        end
        chk("wrap_empty", 32'(bus_a.empty), 32'd1);

        // Full boundary.
        for (int i = 0; i < 5; i++) a_op(1, 0, 16'(16'h31 + i), 0, '0);
        a_op(1, 1, 16'h36, 1, 16'h31);
        chk("full_pp_count", 32'(bus_a.count), 32'd5);
        chk("full_pp_ovf", 32'(bus_a.overflow), 32'd0);
        a_op(1, 0, 16'h37, 0, '0);
        chk("full_push_ovf", 32'(bus_a.overflow), 32'd1);
        chk("full_push_count", 32'(bus_a.count), 32'd5);
        step();
        chk("ovf_sticky", 32'(bus_a.overflow), 32'd1);
        bus_a.err_clr = 1'b1;
        step();
        bus_a.err_clr = 1'b0;
        chk("ovf_cleared", 32'(bus_a.overflow), 32'd0);
        for (int i = 0; i < 5; i++) a_op(0, 1, '0, 1, 16'(16'h32 + i));
        // Rejected pop on empty keeps the last word and flags underflow.
        a_op(0, 1, '0, 0, '0);
        chk("a_unf", 32'(bus_a.underflow), 32'd1);
        chk("a_rdata_hold", 32'(bus_a.rdata), 32'h36);

        // Empty boundary on the FWFT instance.
        b_op(1, 1, 16'hA5A5, 1, 0);
        chk("b_pp_count", 32'(bus_b.count), 32'd1);
        chk("b_pp_unf", 32'(bus_b.underflow), 32'd1);
        chk("b_pp_rdata", 32'(bus_b.rdata), 32'hA5A5);
        b_op(0, 1, '0, 0, 1);
        chk("b_pop_empty", 32'(bus_b.empty), 32'd1);
        chk("b_pop_rdata", 32'(bus_b.rdata), 32'd0);
        bus_b.err_clr = 1'b1;
        step();
        bus_b.err_clr = 1'b0;
        chk("b_unf_cleared", 32'(bus_b.underflow), 32'd0);

        // Thresholds, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2.
        for (int i = 0; i < 8; i++) begin
            b_op(1, 0, 16'(16'h100 + i), 1, 0);
            chk("thr_count", 32'(bus_b.count), 32'(i + 1));
            chk("thr_aempty", 32'(bus_b.aempty), 32'((i + 1) <= 2));
            chk("thr_afull", 32'(bus_b.afull), 32'((i + 1) >= 6));
            chk("thr_full", 32'(bus_b.full), 32'((i + 1) == 8));
        end
        b_op(1, 0, 16'hDEAD, 0, 0);
        chk("b_ovf", 32'(bus_b.overflow), 32'd1);
        bus_b.err_clr = 1'b1;
        step();
        bus_b.err_clr = 1'b0;
        for (int i = 0; i < 4; i++) b_op(0, 1, '0, 0, 1);
        chk("pre_clr_count", 32'(bus_b.count), 32'd4);

        // Flush with push+pop in the same cycle.
        bus_b.clr = 1'b1;
        b_op(1, 1, 16'hBEEF, 0, 0);
        bus_b.clr = 1'b0;
        qb.delete();
        chk("clr_count", 32'(bus_b.count), 32'd0);
        chk("clr_empty", 32'(bus_b.empty), 32'd1);
        chk("clr_ovf", 32'(bus_b.overflow), 32'd0);
        chk("clr_unf", 32'(bus_b.underflow), 32'd0);

        // Reset mid-cycle at count=3.
        for (int i = 1; i <= 3; i++) b_op(1, 0, 16'(16'h200 + i), 1, 0);
        chk("prerst_count", 32'(bus_b.count), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_b("midrst");
        chk_reset_a("midrst");
        qb.delete();
        step();
        rst_n = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
